// File: rtl/int_inj_pkg.sv
// int_inj_pkg: shared types and constants for the interrupt injector.
//   int_inj_state_e   controller state (armed / asserting / re-arming / done)
//   WORD_MASK         clears the byte-offset bits of a 32-bit address
//   DEFAULT_TARGET_PC default PC that triggers an interrupt
//   DEFAULT_ACK_ADDR  default interrupt-ack word address
package int_inj_pkg;

   typedef enum logic [1:0] {
      StArmed,
      StAssert,
      StRearm,
      StDone
   } int_inj_state_e;

   localparam logic [31:0] WORD_MASK         = 32'hFFFF_FFFC;
   localparam logic [31:0] DEFAULT_TARGET_PC = 32'h0000_3010;
   localparam logic [31:0] DEFAULT_ACK_ADDR  = 32'h0000_7F20;

endpackage

// File: rtl/int_inj_ack_detect.sv
// int_inj_ack_detect: combinational word-aligned write decode.
// Ports:
//   addr    in  32  write address (byte offset bits ignored)
//   byteen  in  4   byte enables; any bit set means a write
//   ack     out 1   write to the ACK_ADDR word
module int_inj_ack_detect
   import int_inj_pkg::*;
#(
   parameter logic [31:0] ACK_ADDR = DEFAULT_ACK_ADDR
) (
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   output logic        ack
);

   assign ack = (|byteen) && ((addr & WORD_MASK) == (ACK_ADDR & WORD_MASK));

endmodule

// File: rtl/int_injector.sv
// int_injector: raises an interrupt when the CPU PC reaches TARGET_PC and holds it
// until the handler writes the ack word at ACK_ADDR. Re-arms (after the PC leaves
// the target) up to MAX_FIRES times; MAX_FIRES = 0 means unlimited.
// Optional: define INT_INJ_TIMEOUT_EN to abandon an unacknowledged interrupt after
// TIMEOUT_CYCLES cycles and set the sticky timeout_err flag.
// Ports:
//   clk             in  1   system clock
//   reset           in  1   synchronous active-high reset
//   macroscopic_pc  in  32  CPU architectural PC
//   m_int_addr      in  32  CPU interrupt-device write address
//   m_int_byteen    in  4   CPU interrupt-device byte enables
//   interrupt       out 1   registered interrupt request
//   fire_count      out 8   acknowledged interrupts, saturating at 255
//   busy            out 1   high while asserting an interrupt
//   timeout_err     out 1   sticky ack-timeout flag (0 when timeout disabled)
module int_injector
   import int_inj_pkg::*;
#(
   parameter logic [31:0] TARGET_PC      = DEFAULT_TARGET_PC,
   parameter logic [31:0] ACK_ADDR       = DEFAULT_ACK_ADDR,
   parameter int unsigned MAX_FIRES      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] macroscopic_pc,
   input  logic [31:0] m_int_addr,
   input  logic [3:0]  m_int_byteen,
   output logic        interrupt,
   output logic [7:0]  fire_count,
   output logic        busy,
   output logic        timeout_err
);

   int_inj_state_e state;
   logic           pc_hit;
   logic           ack;
   logic [7:0]     count_inc;
   logic           last_fire;

   assign pc_hit = (macroscopic_pc & WORD_MASK) == (TARGET_PC & WORD_MASK);

   int_inj_ack_detect #(
      .ACK_ADDR (ACK_ADDR)
   ) u_ack_detect (
      .addr   (m_int_addr),
      .byteen (m_int_byteen),
      .ack    (ack)
   );

   assign count_inc = (fire_count == 8'hFF) ? fire_count : fire_count + 8'd1;
   assign last_fire = (MAX_FIRES != 0) && ({24'd0, count_inc} == MAX_FIRES);

`ifdef INT_INJ_TIMEOUT_EN
   logic [31:0] timer;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StArmed;
         interrupt  <= 1'b0;
         busy       <= 1'b0;
         fire_count <= 8'd0;
`ifdef INT_INJ_TIMEOUT_EN
         timer       <= 32'd0;
         timeout_err <= 1'b0;
`endif
      end else begin
         unique case (state)
            StArmed: begin
               // A simultaneous ack is ignored here: the hit wins.
               if (pc_hit) begin
                  state     <= StAssert;
                  interrupt <= 1'b1;
                  busy      <= 1'b1;
`ifdef INT_INJ_TIMEOUT_EN
                  timer     <= 32'd0;
`endif
               end
            end
            StAssert: begin
               if (ack) begin
                  interrupt  <= 1'b0;
                  busy       <= 1'b0;
                  fire_count <= count_inc;
                  state      <= last_fire ? StDone : StRearm;
`ifdef INT_INJ_TIMEOUT_EN
               end else if (timer == TIMEOUT_CYCLES - 1) begin
                  interrupt   <= 1'b0;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= StDone;
               end else begin
                  timer <= timer + 32'd1;
`endif
               end
            end
            StRearm: begin
               // The PC must leave the target before another interrupt can fire.
               if (!pc_hit) state <= StArmed;
            end
            StDone: begin
            end
            default: state <= StArmed;
         endcase
      end
   end

endmodule

// File: doc/int_injector.md
Name: int_injector

Overview:
- Interrupt stimulus source for the P7 system. It sits directly upstream of the CPU's `interrupt` input.
- Watches the CPU's macroscopic PC and raises `interrupt` when the PC reaches a programmed target.
- Holds `interrupt` until the handler acknowledges it by writing the interrupt-ack word (default 0x7F20) through the CPU's `m_int_addr`/`m_int_byteen` port.
- Re-arms up to a configurable number of firings.

Parameters:
- TARGET_PC, 32'h0000_3010, word address whose appearance on macroscopic_pc triggers an interrupt (low 2 bits ignored).
- ACK_ADDR, 32'h0000_7F20, word address whose write acknowledges and clears the interrupt (low 2 bits ignored).
- MAX_FIRES, 1, number of interrupts to deliver; 0 = unlimited.
- TIMEOUT_CYCLES, 1024, ack timeout; used only with INT_INJ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- macroscopic_pc  in  32  CPU architectural PC.
- m_int_addr  in  32  CPU interrupt-device write address.
- m_int_byteen  in  4  CPU interrupt-device byte enables; any bit set = write.
- interrupt  out  1  registered interrupt request to CPU.
- fire_count  out  8  number of acknowledged interrupts; saturates at 255.
- busy  out  1  high while in ASSERT.
- timeout_err  out  1  sticky ack-timeout flag.

Behaviour:
- Reset values (synchronous, takes effect at the posedge with reset=1):
  - interrupt=0, fire_count=0, busy=0, timeout_err=0.
  - state=ARMED; internal timeout counter=0.
- Match condition: `pc_hit = (macroscopic_pc & 32'hFFFF_FFFC) == (TARGET_PC & 32'hFFFF_FFFC)`.
- Ack condition: `ack = |m_int_byteen && (m_int_addr & 32'hFFFF_FFFC) == (ACK_ADDR & 32'hFFFF_FFFC)`.
- States:
  - ARMED: on pc_hit go to ASSERT; interrupt=1 from the next posedge (1-cycle latency). An ack seen here is ignored.
  - ASSERT: interrupt=1, busy=1.
    - On ack: interrupt=0 at the next edge and fire_count increments (saturating).
    - If the new count equals MAX_FIRES (MAX_FIRES≠0), go to DONE; otherwise go to REARM.
  - REARM: interrupt=0. Go to ARMED on the first cycle with !pc_hit. This stops a stalled or looping PC at TARGET_PC from re-triggering without leaving it first.
  - DONE: interrupt=0; terminal until reset. pc_hit and ack are ignored.
- Simultaneous events:
  - pc_hit and ack in the same ARMED cycle: pc_hit wins, go to ASSERT.
  - pc_hit and ack in the same ASSERT cycle: ack wins.
- MAX_FIRES=0: never enters DONE; cycles ARMED→ASSERT→REARM indefinitely.
- Reset during ASSERT: interrupt drops at that edge and the block returns to ARMED with count 0.
- Output rule: interrupt, busy and timeout_err are all registered; no combinational path from inputs to outputs.

Optional Feature:
- INT_INJ_TIMEOUT_EN defined:
  - A counter runs while in ASSERT and clears on entry to ASSERT.
  - If it reaches TIMEOUT_CYCLES with no ack: interrupt=0, timeout_err=1 (sticky until reset), state=DONE, fire_count unchanged.
  - An ack in the same cycle as the timeout wins.
- INT_INJ_TIMEOUT_EN undefined: ASSERT waits indefinitely; timeout_err is tied 0 and the counter is absent.

Decomposition:
- Package int_inj_pkg holds:
  - the state enum {ARMED, ASSERT, REARM, DONE};
  - the WORD_MASK constant 32'hFFFF_FFFC;
  - default TARGET_PC and ACK_ADDR constants.
- One natural sub-module: int_inj_ack_detect, a combinational ack decode of addr/byteen against ACK_ADDR. It is reused by any other bus device that needs the same word-aligned write decode.

Test Plan:
- Basic fire/ack, defaults:
  - Stimulus: hold PC=0x3000, then PC=0x3010 for 1 cycle.
  - Response: interrupt=1 from the next edge. Write addr 0x7F20 with byteen=4'hF; interrupt=0 next edge, fire_count=1, state DONE.
- Unaligned and partial ack:
  - Stimulus: in ASSERT, write addr 0x7F23 with byteen=4'b0001.
  - Response: treated as ack. A write to 0x7F24 with byteen=4'hF, or to 0x7F20 with byteen=0, leaves interrupt=1.
- Re-arm with MAX_FIRES=2:
  - Stimulus: PC stays at 0x3010 across the ack.
  - Response: no refire while the PC stays at target. PC goes to 0x3014 then back to 0x3010: second interrupt; after the second ack fire_count=2 and DONE. A third hit gives no interrupt.
- Collisions:
  - Ack in the same cycle as pc_hit in ARMED: interrupt rises.
  - Reset asserted while interrupt=1: interrupt, fire_count and busy are 0 at the next edge; a later pc_hit fires again.
- INT_INJ_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - Stimulus: fire, then no ack.
  - Response: interrupt falls after 8 ASSERT cycles, timeout_err=1 (sticky), fire_count=0, and further pc_hits are ignored.
- MAX_FIRES=0 saturation:
  - Stimulus: 300 fire/ack pairs.
  - Response: fire_count saturates at 255 and interrupts continue.
